uart_tx_feeder: RTL and testbench

- Byte-buffering front end that sits directly upstream of uart_tx.
- Accepts bursts of words from a host-side writer into a circular FIFO.
- Drains the FIFO one word at a time into uart_tx using its i_dv/i_data launch and its o_done/o_active status.
- Lets software or upstream logic issue back-to-back writes without tracking the serial frame timing.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo.sv | 83 ++++++++
 rtl/uart_tx_feeder.sv | 98 +++++++++
 tb/tb_uart_tx_feeder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit path.
// Imported by the feeder FSM and its FIFO.
package uart_pkg;

    localparam int c_WORD_LEN = 8;
    localparam int c_CLK_DIV  = 104;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Circular word FIFO with count-derived registered flags and a one-cycle overflow pulse.
// Read data is combinational from the head entry so the consumer can latch it on the pop edge.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int p_WORD_LEN = c_WORD_LEN,
    parameter int p_DEPTH    = 16,
    parameter int p_ADDR_W   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [p_WORD_LEN-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [p_WORD_LEN-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [p_ADDR_W:0]     o_count,
    output logic                  o_overflow
);

    localparam logic [p_ADDR_W:0] c_FULL_COUNT = (p_ADDR_W + 1)'(p_DEPTH);

    logic [p_WORD_LEN-1:0] r_mem [p_DEPTH];
    logic [p_ADDR_W-1:0]   r_wr_ptr;
    logic [p_ADDR_W-1:0]   r_rd_ptr;
    logic [p_ADDR_W:0]     r_count;
    logic [p_ADDR_W:0]     w_count_next;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    // Gating on the registered full flag means a same-cycle pop never frees room for a write.
    assign w_wr_accept = i_wr_en && !r_full;
    assign w_rd_accept = i_rd_en && !r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_accept && !w_rd_accept) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_wr_accept && w_rd_accept) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_empty    <= (w_count_next == '0);
            r_full     <= (w_count_next == c_FULL_COUNT);
            r_overflow <= i_wr_en && r_full;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains the word FIFO into uart_tx one frame at a time, leaving at least one
// idle cycle between the transmitter's done pulse and the next launch.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int p_WORD_LEN = c_WORD_LEN,
    parameter int p_DEPTH    = 16,
    parameter int p_ADDR_W   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [p_WORD_LEN-1:0] i_wr_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [p_ADDR_W:0]     o_count,
    output logic                  o_overflow,
    output logic                  o_tx_dv,
    output logic [p_WORD_LEN-1:0] o_tx_data,
    input  logic                  i_tx_done,
    input  logic                  i_tx_active
);

    feeder_state_t         r_state;
    feeder_state_t         w_next_state;
    logic                  w_launch;
    logic                  w_empty;
    logic [p_WORD_LEN-1:0] w_rd_data;
    logic                  r_tx_dv;
    logic [p_WORD_LEN-1:0] r_tx_data;

    uart_fifo #(
        .p_WORD_LEN (p_WORD_LEN),
        .p_DEPTH    (p_DEPTH),
        .p_ADDR_W   (p_ADDR_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (w_launch),
        .o_rd_data  (w_rd_data),
        .o_full     (o_full),
        .o_empty    (w_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    // Gating on i_tx_active also covers a frame still in flight after our own reset.
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !i_tx_active) begin
                    w_launch     = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (i_tx_done) begin
                    w_next_state = GAP;
                end
            end
            GAP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_dv   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_dv <= w_launch;
            if (w_launch) begin
                r_tx_data <= w_rd_data;
            end
        end
    end

    assign o_empty   = w_empty;
    assign o_tx_dv   = r_tx_dv;
    assign o_tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a queue-based reference model plus a
// behavioural transmitter stub that answers each launch with a fixed-length frame.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int FRAME = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrEn;
    logic [7:0] wrData;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       ovf;
    logic       txDv;
    logic [7:0] txData;
    logic       txDone;
    logic       txActive;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .p_WORD_LEN (8),
        .p_DEPTH    (DEPTH),
        .p_ADDR_W   (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wrEn),
        .i_wr_data   (wrData),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (count),
        .o_overflow  (ovf),
        .o_tx_dv     (txDv),
        .o_tx_data   (txData),
        .i_tx_done   (txDone),
        .i_tx_active (txActive)
    );

    typedef struct {
        bit         wr;
        logic [7:0] data;
        int         expCount;
        bit         expFull;
        bit         expOvf;
    } vec_t;

    int         compared    = 0;
    int         mismatched  = 0;
    int         cycle       = 0;
    int         txCnt       = 0;
    bit         forceActive = 1'b0;
    bit         expOvf      = 1'b0;
    int         lastDone    = -100;
    int         waitCycles  = 0;
    int         dvCount     = 0;
    int         maxCount    = 0;
    logic [7:0] expData     = 8'h00;
    logic [7:0] mq[$];
    logic [7:0] launched[$];
    vec_t       fillTable[18];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic setForce(input bit v);
        forceActive = v;
        txActive    = forceActive || (txCnt > 0);
    endtask

    // One clock: advance the transmitter stub, update the model, compare every visible output.
    task automatic tick();
        bit         preWr;
        logic [7:0] preData;
        bit         preActive;
        bit         preRst;
        int         preSize;
        preWr     = wrEn;
        preData   = wrData;
        preActive = txActive;
        preRst    = rst;
        preSize   = mq.size();
        @(posedge clk);
        #1;
        cycle++;
        txDone = 1'b0;
        if (txCnt > 0) begin
            txCnt--;
            if (txCnt == 0) begin
                txDone   = 1'b1;
                lastDone = cycle;
            end
        end
        if (preRst) begin
            mq.delete();
            expOvf     = 1'b0;
            expData    = 8'h00;
            waitCycles = 0;
            checkOutput("dv_in_reset", txDv, 0);
        end else begin
            if (txDv) begin
                dvCount++;
                waitCycles = 0;
                checkOutput("dv_while_active", preActive, 0);
                checkOutput("dv_gap_after_done", (cycle - lastDone) >= 2, 1);
                checkOutput("dv_fifo_nonempty", preSize > 0, 1);
                if (preSize > 0) begin
                    checkOutput("dv_data_order", txData, mq[0]);
                    void'(mq.pop_front());
                end
                launched.push_back(txData);
                expData = txData;
                txCnt   = FRAME;
            end else begin
                checkOutput("tx_data_hold", txData, expData);
                if (preSize > 0 && !preActive) begin
                    waitCycles++;
                    if (waitCycles > 4) begin
                        checkOutput("launch_stall_cycles", waitCycles, 0);
                        waitCycles = 0;
                    end
                end else begin
                    waitCycles = 0;
                end
            end
            if (preWr) begin
                if (preSize < DEPTH) begin
                    mq.push_back(preData);
                    expOvf = 1'b0;
                end else begin
                    expOvf = 1'b1;
                end
            end else begin
                expOvf = 1'b0;
            end
        end
        txActive = forceActive || (txCnt > 0);
        checkOutput("count", count, mq.size());
        checkOutput("empty", empty, mq.size() == 0);
        checkOutput("full", full, mq.size() == DEPTH);
        checkOutput("overflow", ovf, expOvf);
        if (mq.size() > maxCount) maxCount = mq.size();
    endtask

    task automatic applyStimulus(input bit en, input logic [7:0] d);
        wrEn   = en;
        wrData = d;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic drainUntil(input int target, input int budget, input string name);
        int guard;
        guard = 0;
        while (dvCount < target && guard < budget) begin
            applyStimulus(1'b0, 8'h00);
            guard++;
        end
        if (dvCount < target) checkOutput(name, dvCount, target);
    endtask

    initial begin
        int         base;
        logic [7:0] written[$];

        for (int i = 0; i < 18; i++) begin
            fillTable[i].wr       = (i < 17);
            fillTable[i].data     = 8'(8'h40 + i);
            fillTable[i].expCount = (i < DEPTH) ? i + 1 : DEPTH;
            fillTable[i].expFull  = (i >= DEPTH - 1);
            fillTable[i].expOvf   = (i == 16);
        end

        rst      = 1'b1;
        wrEn     = 1'b0;
        wrData   = 8'h00;
        txDone   = 1'b0;
        txActive = 1'b0;
        tick();
        tick();
        checkOutput("reset_tx_dv", txDv, 0);
        checkOutput("reset_tx_data", txData, 0);
        checkOutput("reset_empty", empty, 1);
        rst = 1'b0;
        idle(2);

        $display("[TB] single write latency");
        applyStimulus(1'b1, 8'hA5);
        checkOutput("latency_dv_cycle1", txDv, 0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("latency_dv_cycle2", txDv, 1);
        checkOutput("latency_data", txData, 8'hA5);
        applyStimulus(1'b0, 8'h00);
        checkOutput("dv_one_cycle", txDv, 0);
        idle(12);
        checkOutput("single_empty_after", empty, 1);

        $display("[TB] burst 01..05");
        maxCount = 0;
        base     = dvCount;
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i));
        drainUntil(base + 5, 100, "burst_drain_timeout");
        idle(12);
        checkOutput("burst_launches", dvCount - base, 5);
        checkOutput("burst_peak_count", maxCount, 4);
        for (int i = 0; i < 5; i++) checkOutput("burst_order", launched[base + i], i + 1);

        $display("[TB] fill past depth while transmitter busy");
        setForce(1'b1);
        base = dvCount;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(fillTable[i].wr, fillTable[i].data);
            checkOutput("fill_count", count, fillTable[i].expCount);
            checkOutput("fill_full", full, fillTable[i].expFull);
            checkOutput("fill_overflow", ovf, fillTable[i].expOvf);
        end
        setForce(1'b0);
        drainUntil(base + 16, 300, "fill_drain_timeout");
        idle(20);
        checkOutput("fill_drained", dvCount - base, 16);
        checkOutput("fill_final_count", count, 0);

        $display("[TB] pointer wrap");
        written.delete();
        setForce(1'b1);
        base = dvCount;
        for (int i = 0; i < 16; i++) begin
            written.push_back(8'(8'h80 + i));
            applyStimulus(1'b1, 8'(8'h80 + i));
        end
        setForce(1'b0);
        drainUntil(base + 10, 200, "wrap_drain_timeout");
        setForce(1'b1);
        checkOutput("wrap_mid_count", count, 6);
        for (int i = 0; i < 10; i++) begin
            written.push_back(8'(8'hC0 + i));
            applyStimulus(1'b1, 8'(8'hC0 + i));
        end
        checkOutput("wrap_refill_full", full, 1);
        setForce(1'b0);
        drainUntil(base + 26, 400, "wrap_final_timeout");
        idle(20);
        checkOutput("wrap_final_count", count, 0);
        for (int i = 0; i < 26; i++) checkOutput("wrap_order", launched[base + i], written[i]);

        $display("[TB] simultaneous write and pop");
        setForce(1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h20 + i));
        checkOutput("simul_pre_count", count, 3);
        setForce(1'b0);
        applyStimulus(1'b1, 8'h23);
        checkOutput("simul_dv", txDv, 1);
        checkOutput("simul_count", count, 3);
        checkOutput("simul_full", full, 0);
        checkOutput("simul_empty", empty, 0);
        idle(60);

        $display("[TB] reset mid-frame");
        setForce(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h50 + i));
        checkOutput("rst_pre_count", count, 4);
        rst  = 1'b1;
        wrEn = 1'b0;
        #1;
        checkOutput("rst_async_count", count, 0);
        checkOutput("rst_async_empty", empty, 1);
        tick();
        rst = 1'b0;
        base = dvCount;
        applyStimulus(1'b1, 8'h3C);
        idle(5);
        checkOutput("rst_no_launch_while_active", dvCount - base, 0);
        checkOutput("rst_queued_count", count, 1);
        setForce(1'b0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("rst_launch_dv", txDv, 1);
        checkOutput("rst_launch_data", txData, 8'h3C);
        idle(15);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) setForce(!forceActive);
            applyStimulus($urandom_range(0, 2) == 0, 8'($urandom));
        end
        setForce(1'b0);
        drainUntil(dvCount + mq.size(), 400, "random_drain_timeout");
        idle(20);
        checkOutput("random_final_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
